// File: rtl/jtframe_hsize_ctrl.sv
// Horizontal scaler control: measures line timing, locks onto stable video
// and applies scaler settings only at vblank. Option: JTFRAME_HSIZE_WATCHDOG_EN
module jtframe_hsize_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       HS,
    input  logic       VS,
    input  logic       HB,
    input  logic       VB,
    input  logic [3:0] req_scale,
    input  logic [4:0] req_offset,
    input  logic       req_enable,
    output logic [3:0] scale,
    output logic [4:0] offset,
    output logic       enable,
    output logic       locked,
    output logic       pending,
    output logic [8:0] htotal,
    output logic [8:0] hactive
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        PENDING  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_hs_l;
    logic       r_vs_l;
    logic       r_hb_l;
    logic       r_vb_l;
    logic       w_hs_rise;
    logic       w_vs_rise;
    logic       w_hb_rise;
    logic       w_vb_rise;

    logic [8:0] r_hcnt;
    logic [8:0] r_acnt;
    logic [8:0] w_hcnt_inc;
    logic [8:0] r_htotal_cur;
    logic [8:0] r_hactive_cur;
    logic [8:0] r_htotal_prv;
    logic [8:0] r_hactive_prv;

    logic [1:0] r_stable;
    logic [1:0] w_stable_nxt;
    logic       w_match;
    logic       w_lost;
    logic       w_wd_fire;
    logic       w_req_diff;

    logic [3:0] r_scale;
    logic [4:0] r_offset;
    logic       r_enable;
    logic [3:0] w_scale_nxt;
    logic [4:0] w_offset_nxt;
    logic       w_enable_nxt;

    assign w_hs_rise = pxl_cen & HS & ~r_hs_l;
    assign w_vs_rise = pxl_cen & VS & ~r_vs_l;
    assign w_hb_rise = pxl_cen & HB & ~r_hb_l;
    assign w_vb_rise = pxl_cen & VB & ~r_vb_l;

    // Delayed copies of the timing inputs for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_l <= 1'b0;
            r_vs_l <= 1'b0;
            r_hb_l <= 1'b0;
            r_vb_l <= 1'b0;
        end else if (pxl_cen) begin
            r_hs_l <= HS;
            r_vs_l <= VS;
            r_hb_l <= HB;
            r_vb_l <= VB;
        end
    end

    // The latched total includes the HS-rise pixel itself so it equals the line length
    assign w_hcnt_inc = (r_hcnt == 9'd511) ? 9'd511 : r_hcnt + 9'd1;

    // Line length measurement between HS rises
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt       <= 9'd0;
            r_htotal_cur <= 9'd0;
        end else if (pxl_cen) begin
            if (w_hs_rise) begin
                r_htotal_cur <= w_hcnt_inc;
                r_hcnt       <= 9'd0;
            end else begin
                r_hcnt <= w_hcnt_inc;
            end
        end
    end

    // Active pixel measurement, closed by HB rise on visible lines
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acnt        <= 9'd0;
            r_hactive_cur <= 9'd0;
        end else if (pxl_cen) begin
            if (w_hb_rise && !VB) begin
                r_hactive_cur <= r_acnt;
                r_acnt        <= 9'd0;
            end else if (!HB && !VB && r_acnt != 9'd511) begin
                r_acnt <= r_acnt + 9'd1;
            end
        end
    end

`ifdef JTFRAME_HSIZE_WATCHDOG_EN
    logic [10:0] r_wd;

    assign w_wd_fire = pxl_cen & ~w_hs_rise & (r_wd == 11'd1023);

    // Missing-HS watchdog, saturates at 1024 until the next HS rise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd <= 11'd0;
        end else if (pxl_cen) begin
            if (w_hs_rise) begin
                r_wd <= 11'd0;
            end else if (r_wd != 11'd1024) begin
                r_wd <= r_wd + 11'd1;
            end
        end
    end
`else
    assign w_wd_fire = 1'b0;
`endif

    assign w_match = (r_htotal_cur == r_htotal_prv) &&
                     (r_hactive_cur == r_hactive_prv) &&
                     (r_htotal_cur != 9'd511) &&
                     (r_hactive_cur != 9'd511);

    assign w_lost = (w_vs_rise & ~w_match) | w_wd_fire;

    assign w_req_diff = {req_scale, req_offset, req_enable} !=
                        {r_scale, r_offset, r_enable};

    // Frame-to-frame stability counter
    always_comb begin
        w_stable_nxt = r_stable;
        if (w_wd_fire) begin
            w_stable_nxt = 2'd0;
        end else if (w_vs_rise) begin
            if (w_match) begin
                w_stable_nxt = (r_stable == 2'd3) ? 2'd3 : r_stable + 2'd1;
            end else begin
                w_stable_nxt = 2'd0;
            end
        end
    end

    // Stability state and per-frame measurement snapshot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable      <= 2'd0;
            r_htotal_prv  <= 9'd0;
            r_hactive_prv <= 9'd0;
            htotal        <= 9'd0;
            hactive       <= 9'd0;
        end else begin
            r_stable <= w_stable_nxt;
            if (w_vs_rise) begin
                r_htotal_prv  <= r_htotal_cur;
                r_hactive_prv <= r_hactive_cur;
                htotal        <= r_htotal_cur;
                hactive       <= r_hactive_cur;
            end
        end
    end

    // Lock FSM next state and applied settings
    always_comb begin
        w_state_nxt  = r_state;
        w_scale_nxt  = r_scale;
        w_offset_nxt = r_offset;
        w_enable_nxt = r_enable;
        unique case (r_state)
            UNLOCKED: begin
                w_enable_nxt = 1'b0;
                if (w_vs_rise && !w_wd_fire && w_stable_nxt == 2'd3) begin
                    w_state_nxt  = LOCKED;
                    w_scale_nxt  = req_scale;
                    w_offset_nxt = req_offset;
                    w_enable_nxt = req_enable;
                end
            end
            LOCKED: begin
                if (w_lost) begin
                    w_state_nxt  = UNLOCKED;
                    w_enable_nxt = 1'b0;
                end else if (w_req_diff) begin
                    w_state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (w_lost) begin
                    w_state_nxt  = UNLOCKED;
                    w_enable_nxt = 1'b0;
                end else if (w_vb_rise) begin
                    w_state_nxt  = LOCKED;
                    w_scale_nxt  = req_scale;
                    w_offset_nxt = req_offset;
                    w_enable_nxt = req_enable;
                end else if (!w_req_diff) begin
                    w_state_nxt = LOCKED;
                end
            end
            default: begin
                w_state_nxt  = UNLOCKED;
                w_enable_nxt = 1'b0;
            end
        endcase
    end

    // Lock FSM state and applied settings registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= UNLOCKED;
            r_scale  <= 4'd0;
            r_offset <= 5'd0;
            r_enable <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_scale  <= w_scale_nxt;
            r_offset <= w_offset_nxt;
            r_enable <= w_enable_nxt;
        end
    end

    assign scale   = r_scale;
    assign offset  = r_offset;
    assign enable  = r_enable;
    assign locked  = (r_state != UNLOCKED);
    assign pending = (r_state == PENDING);

endmodule

// File: doc/jtframe_hsize_ctrl.md
JTFRAME_HSIZE_CTRL -- requirements
Module: jtframe_hsize_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have ports: pxl_cen  in  1  pixel clock enable; all counting and sampling is qualified by it.
REQ-004 SHALL have ports: HS, VS, HB, VB  in  1 each  raw video timing from the core.
REQ-005 SHALL have ports: req_scale  in  4  requested scale; req_offset  in  5  requested offset; req_enable  in  1  requested scaler enable.
REQ-006 SHALL have ports: scale  out  4; offset  out  5; enable  out  1  applied settings driven to the horizontal scaler.
REQ-007 SHALL have ports: locked  out  1  timing stable; pending  out  1  request waiting for vblank; htotal  out  9  pixels per line; hactive  out  9  active pixels per line.

Function
REQ-008 SHALL detect HS/VS/HB/VB rising edges against a copy registered on pxl_cen; edges are acted on only in pxl_cen cycles.
REQ-009 SHALL count pxl_cen cycles in hcnt (9 bit, saturating at 511); on an HS rise it latches hcnt into htotal_cur and clears hcnt to 0.
REQ-010 SHALL count pxl_cen cycles with HB=0 and VB=0 in acnt (9 bit, saturating); on an HB rise with VB=0 it latches acnt into hactive_cur and clears acnt.
REQ-011 SHALL, on each VS rise, compare {htotal_cur, hactive_cur} with the previous frame's values: equal and neither saturated -> 2-bit stable counter increments, saturating at 3; otherwise -> stable cleared to 0; the current values are then stored as previous.
REQ-012 SHALL update htotal and hactive outputs from the stored values only on VS rise.
REQ-013 SHALL implement states UNLOCKED, LOCKED, PENDING; locked=1 in LOCKED and PENDING; pending=1 only in PENDING.
REQ-014 UNLOCKED -> LOCKED when stable reaches 3; on entry, {scale,offset,enable} load req_* in the same cycle.
REQ-015 LOCKED -> PENDING when {req_scale,req_offset,req_enable} differs from the applied outputs.
REQ-016 PENDING -> LOCKED on the next VB rise: outputs load the req_* values present in that cycle; req_* changes while pending are tracked, and only the latest value is applied.
REQ-017 PENDING -> LOCKED without applying if req_* returns equal to the applied outputs before the VB rise.
REQ-018 LOCKED/PENDING -> UNLOCKED when stable is cleared; in the same cycle, enable=0 and scale/offset hold their last values.
REQ-019 SHALL hold enable=0 whenever the state is UNLOCKED, regardless of req_enable.
REQ-020 Simultaneous VS rise and VB rise in PENDING: the stability check takes priority; if lock is lost, go to UNLOCKED without applying.

Reset
REQ-021 rst=1 SHALL force: state UNLOCKED; stable=0; hcnt=acnt=0; scale=0; offset=0; enable=0; locked=0; pending=0; htotal=hactive=0; all stored measurements=0; edge registers=0.
REQ-022 Reset asserted mid-frame SHALL take effect on the next clk edge, independent of pxl_cen; after release, lock requires three fresh matching frame comparisons.

Configuration
REQ-023 Macro JTFRAME_HSIZE_WATCHDOG_EN defined: an 11-bit counter of pxl_cen cycles, cleared on each HS rise; on reaching 1024 -> stable=0, state UNLOCKED, enable=0, counter saturates until the next HS rise.
REQ-024 Macro JTFRAME_HSIZE_WATCHDOG_EN undefined: no watchdog logic; lock is lost only through REQ-018.

Verification
REQ-025 Stable 384-total/256-active lines, 264-line frames, req_enable=1, req_scale=4'd5 -> locked=1 after the 4th VS rise, with enable=1, scale=5, htotal=384, hactive=256.
REQ-026 While locked, req_offset changes 0 -> 5'd3 mid-frame -> pending=1 and offset stays 0 until the VB rise, then offset=3 and pending=0.
REQ-027 While pending, req_offset changes 3 -> 7 -> 0 before VB, with applied=0 -> pending clears with no output change; or, with final value 7, offset=7 at the VB rise.
REQ-028 One frame with 383-pixel lines -> stable=0, locked=0, and enable=0 at that VS rise; relock after three further matching frames.
REQ-029 JTFRAME_HSIZE_WATCHDOG_EN defined, HS stopped while locked -> locked=0 and enable=0 exactly 1024 pxl_cen cycles after the last HS rise; undefined -> locked stays 1.
REQ-030 rst pulsed for one cycle mid-line while locked -> next cycle all outputs equal the REQ-021 values.
